// File: rtl/dma_mem_pkg.sv
// rtl/dma_mem_pkg.sv - shared DMA memory interface defaults, limits and access decode
package dma_mem_pkg;

    localparam int DEF_ADDR_W     = 4;
    localparam int DEF_DATA_W     = 8;
    localparam int DEF_CNT_W      = 8;
    localparam int DEF_RD_LATENCY = 2;
    localparam int RD_LAT_MIN     = 1;
    localparam int RD_LAT_MAX     = 4;

    typedef enum logic [1:0] {
        ACC_IDLE  = 2'd0,
        ACC_READ  = 2'd1,
        ACC_WRITE = 2'd2
    } acc_kind_e;

    // we_n only matters when the chip is enabled
    function automatic acc_kind_e decode_access(logic ce_n, logic we_n);
        if (ce_n) return ACC_IDLE;
        return we_n ? ACC_READ : ACC_WRITE;
    endfunction

endpackage

// File: rtl/dma_mem_responder_if.sv
// rtl/dma_mem_responder_if.sv - DMA memory bus between initiator and memory responder
interface dma_mem_responder_if
    import dma_mem_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              mem_ce_n;
    logic              mem_we_n;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_data_in;
    logic [DATA_W-1:0] mem_data_out;
    logic              rd_valid;
    logic              wr_err;

    modport master (
        output mem_ce_n, mem_we_n, mem_addr, mem_data_in,
        input  mem_data_out, rd_valid, wr_err
    );

    modport slave (
        input  mem_ce_n, mem_we_n, mem_addr, mem_data_in,
        output mem_data_out, rd_valid, wr_err
    );
endinterface

// File: rtl/dma_mem_rd_pipe.sv
// rtl/dma_mem_rd_pipe.sv - fixed-latency {valid,data} read return pipeline
module dma_mem_rd_pipe #(
    parameter int RD_LATENCY = 2,
    parameter int DATA_W     = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data
);
    logic [RD_LATENCY-1:0] vld;
    logic [DATA_W-1:0]     dat [RD_LATENCY];

    // data stages only load on a valid beat, so the last stage holds the last read value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < RD_LATENCY; i++) dat[i] <= '0;
        end else begin
            for (int i = RD_LATENCY - 1; i > 0; i--) begin
                vld[i] <= vld[i-1];
                if (vld[i-1]) dat[i] <= dat[i-1];
            end
            vld[0] <= in_valid;
            if (in_valid) dat[0] <= in_data;
        end
    end

    assign out_valid = vld[RD_LATENCY-1];
    assign out_data  = dat[RD_LATENCY-1];
endmodule

// File: rtl/dma_mem_responder.sv
// rtl/dma_mem_responder.sv - register-file memory responder with write protection and access counters
module dma_mem_responder
    import dma_mem_pkg::*;
#(
    parameter int ADDR_W     = DEF_ADDR_W,
    parameter int DATA_W     = DEF_DATA_W,
    parameter int RD_LATENCY = DEF_RD_LATENCY,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dma_mem_responder_if.slave   bus,
    input  logic [2**ADDR_W-1:0] wp_mask,
    input  logic                 cnt_clr,
    output logic [CNT_W-1:0]     rd_cnt,
    output logic [CNT_W-1:0]     wr_cnt,
    output logic [CNT_W-1:0]     err_cnt
);
    localparam int DEPTH = 2**ADDR_W;

    if (RD_LATENCY < RD_LAT_MIN || RD_LATENCY > RD_LAT_MAX) begin : g_bad_latency
        $error("dma_mem_responder: RD_LATENCY must be within 1..4");
    end

    acc_kind_e         acc;
    logic              wr_prot;
    logic              do_read;
    logic              do_write;
    logic              do_reject;
    logic [DATA_W-1:0] mem [DEPTH];
    logic              pipe_valid;
    logic [DATA_W-1:0] pipe_data;

    assign acc       = decode_access(bus.mem_ce_n, bus.mem_we_n);
    assign wr_prot   = wp_mask[bus.mem_addr];
    assign do_read   = (acc == ACC_READ);
    assign do_write  = (acc == ACC_WRITE) && !wr_prot;
    assign do_reject = (acc == ACC_WRITE) && wr_prot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (do_write) begin
            mem[bus.mem_addr] <= bus.mem_data_in;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) bus.wr_err <= 1'b0;
        else        bus.wr_err <= do_reject;
    end

    // clear wins over any increment in the same cycle; counters stick at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            err_cnt <= '0;
        end else if (cnt_clr) begin
            rd_cnt  <= '0;
            wr_cnt  <= '0;
            err_cnt <= '0;
        end else begin
            if (do_read   && !(&rd_cnt))  rd_cnt  <= rd_cnt + 1'b1;
            if (do_write  && !(&wr_cnt))  wr_cnt  <= wr_cnt + 1'b1;
            if (do_reject && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
        end
    end

    // the read word is taken from pre-edge memory, so earlier writes are visible
    dma_mem_rd_pipe #(
        .RD_LATENCY (RD_LATENCY),
        .DATA_W     (DATA_W)
    ) u_rd_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (do_read),
        .in_data   (mem[bus.mem_addr]),
        .out_valid (pipe_valid),
        .out_data  (pipe_data)
    );

    assign bus.rd_valid     = pipe_valid;
    assign bus.mem_data_out = pipe_data;
endmodule
